rv_bus_bridge: RTL and testbench

- Parametrised successor to the RV4028 CPU-side bus adapter.
- Converts a single 32-bit CPU memory request (femtorv-style strobe/busy protocol) into 1, 2 or 4 external bus beats of BUS_WIDTH bits.
- Skips beats whose byte lanes are all masked off, inserts programmable fixed wait states on top of wait_n, and grants the bus to an external master when requested.
- Sits between the core and the external pins; holds no ROM.

---
 rtl/rv_bus_bridge.sv | 239 +++++++++++++++++++++++
 tb/tb_rv_bus_bridge.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv_bus_bridge.sv
// rv_bus_bridge -- CPU-side bus adapter.
//
// Turns one 32-bit CPU request (strobe/busy handshake) into 1, 2 or 4
// external bus beats of BUS_WIDTH bits. Beats whose byte lanes are all
// masked off are skipped. Every beat carries WAIT_CYCLES fixed wait states
// and is further stretched by wait_n. An external master can take the bus
// through busrq_n/busack_n between requests.
//
// Optional feature macro: RV_BUS_BRIDGE_TIMEOUT_EN
//   defined   : a beat stalled by wait_n for TIMEOUT_CYCLES consecutive
//               cycles is force-completed, read slice = all ones, and the
//               sticky bus_err flag is set.
//   undefined : no timeout logic, bus_err tied low.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   cpu_addr/wdata/mask      request address, write data, byte enables
//   cpu_rstrb/wstrb          single-cycle read/write request pulses
//   cpu_rdata                registered read data
//   cpu_rbusy/wbusy          request outstanding (combinational on strobe)
//   bus_err                  sticky timeout flag
//   addr, rd_n, wr_n, msk_n  bus address, strobes, lane mask (active low)
//   mreq_n, iorq_n           cycle active / I/O space (addr[31]=1)
//   wait_n                   target not ready when low
//   busrq_n, busack_n        external bus request / grant
//   data_in, data_out        bus data
//   data_oe                  data_out drive enable
module rv_bus_bridge #(
    parameter int BUS_WIDTH      = 16,
    parameter int WAIT_CYCLES    = 0,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [31:0]            cpu_addr,
    input  logic [31:0]            cpu_wdata,
    input  logic [3:0]             cpu_mask,
    input  logic                   cpu_rstrb,
    input  logic                   cpu_wstrb,
    output logic [31:0]            cpu_rdata,
    output logic                   cpu_rbusy,
    output logic                   cpu_wbusy,
    output logic                   bus_err,
    output logic [31:0]            addr,
    output logic                   rd_n,
    output logic                   wr_n,
    output logic [BUS_WIDTH/8-1:0] msk_n,
    output logic                   mreq_n,
    output logic                   iorq_n,
    input  logic                   wait_n,
    input  logic                   busrq_n,
    output logic                   busack_n,
    input  logic [BUS_WIDTH-1:0]   data_in,
    output logic [BUS_WIDTH-1:0]   data_out,
    output logic                   data_oe
);

    localparam int BEATS = 32 / BUS_WIDTH;
    localparam int LANES = BUS_WIDTH / 8;

    typedef enum logic [1:0] {IDLE, BEAT, RELEASED} state_t;

    typedef struct packed {
        logic             we;
        logic [31:2]      addr;
        logic [31:0]      wdata;
        logic [3:0]       mask;
        logic [BEATS-1:0] en;
    } req_t;

    // A beat is needed if any of its lanes is enabled. A read with no lanes
    // enabled fetches the whole word; a write with no lanes is a no-op.
    function automatic logic [BEATS-1:0] beat_enables(input logic [3:0] mask,
                                                      input logic       we);
        logic [BEATS-1:0] en;
        for (int k = 0; k < BEATS; k++) en[k] = |mask[k*LANES +: LANES];
        if (mask == 4'd0 && !we) en = '1;
        return en;
    endfunction

    // Lowest enabled beat at or above start: {found, index}.
    function automatic logic [2:0] find_beat(input logic [BEATS-1:0] en,
                                             input int               start);
        logic [2:0] r;
        r = 3'b000;
        for (int k = BEATS - 1; k >= 0; k--)
            if (k >= start && en[k]) r = {1'b1, 2'(k)};
        return r;
    endfunction

    state_t           state_q, state_d;
    req_t             req_q;
    logic             pend_q;
    logic [1:0]       beat_q, beat_d;
    logic [3:0]       wcnt_q;
    logic [31:0]      rdata_q;
    logic             enter;

    logic             new_req, new_we, new_valid;
    logic [BEATS-1:0] new_en;
    logic             eff_valid;
    logic [BEATS-1:0] eff_en;
    logic [2:0]       first, nxt;
    logic             in_beat, beat_done, last_done, tmo_hit;
    logic [LANES-1:0] lane_sel;

    logic unused_addr_lsb;
    assign unused_addr_lsb = &{1'b0, cpu_addr[1:0]};

    // Read wins when both strobes are (illegally) asserted together.
    assign new_req   = cpu_rstrb | cpu_wstrb;
    assign new_we    = ~cpu_rstrb;
    assign new_en    = beat_enables(cpu_mask, new_we);
    assign new_valid = new_req && (new_en != '0);

    // IDLE acts on a strobe in the same cycle it arrives, so the first beat
    // starts the cycle after the strobe rather than two cycles later.
    assign eff_valid = new_req ? new_valid : pend_q;
    assign eff_en    = new_req ? new_en    : req_q.en;
    assign first     = find_beat(eff_en, 0);
    assign nxt       = find_beat(req_q.en, int'(beat_q) + 1);

    assign in_beat   = (state_q == BEAT);
    assign beat_done = in_beat && ((wcnt_q == 4'd0 && wait_n) || tmo_hit);
    assign last_done = beat_done && !nxt[2];

    assign cpu_rbusy = cpu_rstrb | (pend_q & ~req_q.we);
    assign cpu_wbusy = cpu_wstrb | (pend_q &  req_q.we);
    assign cpu_rdata = rdata_q;

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            beat_q  <= 2'd0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
        end
    end

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        enter   = 1'b0;
        case (state_q)
            IDLE: begin
                // Bus grant takes priority even over a waiting request.
                if (!busrq_n) begin
                    state_d = RELEASED;
                end else if (eff_valid) begin
                    state_d = BEAT;
                    beat_d  = first[1:0];
                    enter   = 1'b1;
                end
            end
            BEAT: begin
                if (beat_done) begin
                    if (nxt[2]) begin
                        beat_d = nxt[1:0];
                        enter  = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            RELEASED: begin
                if (busrq_n) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // ---------------- request, wait states, read data ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            req_q   <= '0;
            pend_q  <= 1'b0;
            wcnt_q  <= 4'd0;
            rdata_q <= 32'd0;
        end else begin
            if (new_req) begin
                req_q  <= '{we: new_we, addr: cpu_addr[31:2], wdata: cpu_wdata,
                            mask: cpu_mask, en: new_en};
                pend_q <= new_valid;
            end else if (last_done) begin
                pend_q <= 1'b0;
            end

            if (enter)                wcnt_q <= 4'(WAIT_CYCLES);
            else if (wcnt_q != 4'd0)  wcnt_q <= wcnt_q - 4'd1;

            if (beat_done && !req_q.we)
                rdata_q[int'(beat_q)*BUS_WIDTH +: BUS_WIDTH] <=
                    tmo_hit ? {BUS_WIDTH{1'b1}} : data_in;
        end
    end

`ifdef RV_BUS_BRIDGE_TIMEOUT_EN
    logic [15:0] tcnt_q;
    logic        err_q;

    // tcnt_q counts the wait_n-low cycles already seen in this beat; the
    // TIMEOUT_CYCLES-th consecutive low cycle is the one that ends the beat.
    assign tmo_hit = in_beat && !wait_n && (tcnt_q == 16'(TIMEOUT_CYCLES - 1));
    assign bus_err = err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            tcnt_q <= 16'd0;
            err_q  <= 1'b0;
        end else begin
            if (enter || !in_beat || wait_n) tcnt_q <= 16'd0;
            else                             tcnt_q <= tcnt_q + 16'd1;
            if (tmo_hit) err_q <= 1'b1;
        end
    end
`else
    assign tmo_hit = 1'b0;
    assign bus_err = 1'b0;
`endif

    // ---------------- bus pins ----------------
    // A mask-0 read fetches whole words, so all lanes are enabled then.
    assign lane_sel = (req_q.mask == 4'd0) ? {LANES{1'b1}}
                                           : req_q.mask[int'(beat_q)*LANES +: LANES];

    assign addr     = in_beat ? {req_q.addr, 2'(int'(beat_q) * LANES)} : 32'd0;
    assign mreq_n   = ~in_beat;
    assign iorq_n   = ~(in_beat & req_q.addr[31]);
    assign rd_n     = ~(in_beat & ~req_q.we);
    assign wr_n     = ~(in_beat &  req_q.we);
    assign msk_n    = in_beat ? ~lane_sel : {LANES{1'b1}};
    assign data_oe  = in_beat & req_q.we;
    assign data_out = data_oe ? req_q.wdata[int'(beat_q)*BUS_WIDTH +: BUS_WIDTH]
                              : {BUS_WIDTH{1'b0}};
    assign busack_n = (state_q != RELEASED);

endmodule

// File: tb/tb_rv_bus_bridge.sv
// Directed bench for rv_bus_bridge: three instances (16-bit no waits with
// timeout 4, 8-bit, 16-bit with two wait states) share clock, reset and CPU
// address/data; each has its own strobes and bus-side signals.
module tb_rv_bus_bridge;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [31:0] cpu_addr, cpu_wdata;
    logic [3:0]  cpu_mask;

    // instance a: BUS_WIDTH=16, WAIT=0, TIMEOUT=4
    logic        a_rstrb, a_wstrb, a_rbusy, a_wbusy, a_err;
    logic [31:0] a_rdata, a_addr;
    logic        a_rd_n, a_wr_n, a_mreq_n, a_iorq_n, a_wait_n, a_busrq_n, a_busack_n, a_oe;
    logic [1:0]  a_msk_n;
    logic [15:0] a_din, a_dout;

    // instance b: BUS_WIDTH=8, WAIT=0
    logic        b_rstrb, b_wstrb, b_rbusy, b_wbusy, b_err;
    logic [31:0] b_rdata, b_addr;
    logic        b_rd_n, b_wr_n, b_mreq_n, b_iorq_n, b_busack_n, b_oe;
    logic [0:0]  b_msk_n;
    logic [7:0]  b_din, b_dout;

    // instance c: BUS_WIDTH=16, WAIT=2
    logic        c_rstrb, c_wstrb, c_rbusy, c_wbusy, c_err;
    logic [31:0] c_rdata, c_addr;
    logic        c_rd_n, c_wr_n, c_mreq_n, c_iorq_n, c_wait_n, c_busack_n, c_oe;
    logic [1:0]  c_msk_n;
    logic [15:0] c_din, c_dout;

    rv_bus_bridge #(.BUS_WIDTH(16), .WAIT_CYCLES(0), .TIMEOUT_CYCLES(4)) u_a (
        .clk(clk), .rst(rst), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_mask(cpu_mask), .cpu_rstrb(a_rstrb), .cpu_wstrb(a_wstrb),
        .cpu_rdata(a_rdata), .cpu_rbusy(a_rbusy), .cpu_wbusy(a_wbusy),
        .bus_err(a_err), .addr(a_addr), .rd_n(a_rd_n), .wr_n(a_wr_n),
        .msk_n(a_msk_n), .mreq_n(a_mreq_n), .iorq_n(a_iorq_n), .wait_n(a_wait_n),
        .busrq_n(a_busrq_n), .busack_n(a_busack_n), .data_in(a_din),
        .data_out(a_dout), .data_oe(a_oe));

    rv_bus_bridge #(.BUS_WIDTH(8), .WAIT_CYCLES(0)) u_b (
        .clk(clk), .rst(rst), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_mask(cpu_mask), .cpu_rstrb(b_rstrb), .cpu_wstrb(b_wstrb),
        .cpu_rdata(b_rdata), .cpu_rbusy(b_rbusy), .cpu_wbusy(b_wbusy),
        .bus_err(b_err), .addr(b_addr), .rd_n(b_rd_n), .wr_n(b_wr_n),
        .msk_n(b_msk_n), .mreq_n(b_mreq_n), .iorq_n(b_iorq_n), .wait_n(1'b1),
        .busrq_n(1'b1), .busack_n(b_busack_n), .data_in(b_din),
        .data_out(b_dout), .data_oe(b_oe));

    rv_bus_bridge #(.BUS_WIDTH(16), .WAIT_CYCLES(2)) u_c (
        .clk(clk), .rst(rst), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_mask(cpu_mask), .cpu_rstrb(c_rstrb), .cpu_wstrb(c_wstrb),
        .cpu_rdata(c_rdata), .cpu_rbusy(c_rbusy), .cpu_wbusy(c_wbusy),
        .bus_err(c_err), .addr(c_addr), .rd_n(c_rd_n), .wr_n(c_wr_n),
        .msk_n(c_msk_n), .mreq_n(c_mreq_n), .iorq_n(c_iorq_n), .wait_n(c_wait_n),
        .busrq_n(1'b1), .busack_n(c_busack_n), .data_in(c_din),
        .data_out(c_dout), .data_oe(c_oe));

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled
    // on the falling edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        cpu_addr = '0; cpu_wdata = '0; cpu_mask = '0;
        a_rstrb = 0; a_wstrb = 0; a_wait_n = 1; a_busrq_n = 1; a_din = '0;
        b_rstrb = 0; b_wstrb = 0; b_din = '0;
        c_rstrb = 0; c_wstrb = 0; c_wait_n = 1; c_din = '0;
        repeat (2) tick();

        // ---- reset state ----
        smp();
        chk("rst rd_n",     a_rd_n, 1);
        chk("rst wr_n",     a_wr_n, 1);
        chk("rst mreq_n",   a_mreq_n, 1);
        chk("rst iorq_n",   a_iorq_n, 1);
        chk("rst busack_n", a_busack_n, 1);
        chk("rst msk_n",    a_msk_n, 2'b11);
        chk("rst data_oe",  a_oe, 0);
        chk("rst rdata",    a_rdata, 0);
        chk("rst bus_err",  a_err, 0);
        chk("rst addr",     a_addr, 0);
        tick(); rst = 1'b0;

        // ---- 16-bit read, two beats, I/O space ----
        tick();
        a_rstrb = 1; cpu_addr = 32'h8000_1000; cpu_mask = 4'hF;
        smp(); chk("rd16 c0 rbusy", a_rbusy, 1); chk("rd16 c0 rd_n", a_rd_n, 1);
        tick(); a_rstrb = 0; a_din = 16'h1234;
        smp();
        chk("rd16 b0 addr", a_addr, 32'h8000_1000);
        chk("rd16 b0 rd_n", a_rd_n, 0);
        chk("rd16 b0 mreq_n", a_mreq_n, 0);
        chk("rd16 b0 iorq_n", a_iorq_n, 0);
        chk("rd16 b0 msk_n", a_msk_n, 2'b00);
        chk("rd16 b0 rbusy", a_rbusy, 1);
        tick(); a_din = 16'hABCD;
        smp();
        chk("rd16 b1 addr", a_addr, 32'h8000_1002);
        chk("rd16 b1 rbusy", a_rbusy, 1);
        tick();
        smp();
        chk("rd16 done rbusy", a_rbusy, 0);
        chk("rd16 done rd_n", a_rd_n, 1);
        chk("rd16 rdata", a_rdata, 32'hABCD_1234);

        // ---- bus request together with a read strobe ----
        tick();
        a_rstrb = 1; a_busrq_n = 0; cpu_addr = 32'h0000_0010; cpu_mask = 4'hF;
        smp(); chk("brq c0 rbusy", a_rbusy, 1);
        for (int i = 1; i <= 9; i++) begin
            tick();
            a_rstrb = 0;
            if (i == 5) a_busrq_n = 1;
            a_din = (i == 7) ? 16'h0102 : 16'h0304;
            smp();
            if (i <= 5) begin
                chk("brq busack_n low", a_busack_n, 0);
                chk("brq no mreq", a_mreq_n, 1);
                chk("brq no rd", a_rd_n, 1);
            end
            if (i == 6) begin
                chk("brq busack_n high", a_busack_n, 1);
                chk("brq idle rd_n", a_rd_n, 1);
                chk("brq still rbusy", a_rbusy, 1);
            end
            if (i == 7) begin
                chk("brq b0 rd_n", a_rd_n, 0);
                chk("brq b0 addr", a_addr, 32'h0000_0010);
                chk("brq b0 iorq_n", a_iorq_n, 1);
            end
            if (i == 8) chk("brq b1 addr", a_addr, 32'h0000_0012);
            if (i == 9) begin
                chk("brq rbusy", a_rbusy, 0);
                chk("brq rdata", a_rdata, 32'h0304_0102);
            end
        end

        // ---- 8-bit single-lane write ----
        tick();
        b_wstrb = 1; cpu_addr = 32'h0000_2000; cpu_wdata = 32'h1122_3344; cpu_mask = 4'h4;
        smp(); chk("wr8 c0 wbusy", b_wbusy, 1);
        tick(); b_wstrb = 0;
        smp();
        chk("wr8 addr", b_addr, 32'h0000_2002);
        chk("wr8 wr_n", b_wr_n, 0);
        chk("wr8 data_out", b_dout, 8'h22);
        chk("wr8 msk_n", b_msk_n, 1'b0);
        chk("wr8 data_oe", b_oe, 1);
        chk("wr8 wbusy", b_wbusy, 1);
        tick();
        smp();
        chk("wr8 done wbusy", b_wbusy, 0);
        chk("wr8 done wr_n", b_wr_n, 1);
        chk("wr8 done oe", b_oe, 0);

        // ---- write with mask 0: no beat ----
        tick();
        b_wstrb = 1; cpu_mask = 4'h0;
        smp(); chk("wr0 c0 wbusy", b_wbusy, 1);
        tick(); b_wstrb = 0;
        smp();
        chk("wr0 wbusy", b_wbusy, 0);
        chk("wr0 wr_n", b_wr_n, 1);
        chk("wr0 mreq_n", b_mreq_n, 1);

        // ---- wait states plus wait_n on beat 0 ----
        tick();
        c_rstrb = 1; cpu_addr = 32'h0000_0400; cpu_mask = 4'hF;
        smp(); chk("ws c0 rbusy", c_rbusy, 1);
        for (int i = 1; i <= 10; i++) begin
            tick();
            c_rstrb  = 0;
            c_wait_n = !(i >= 3 && i <= 5);
            c_din    = (i <= 6) ? 16'h5566 : 16'h7788;
            smp();
            if (i <= 6)      chk("ws beat0 addr", c_addr, 32'h0000_0400);
            else if (i <= 9) chk("ws beat1 addr", c_addr, 32'h0000_0402);
            if (i <= 9)      chk("ws rd_n", c_rd_n, 0);
        end
        chk("ws rbusy", c_rbusy, 0);
        chk("ws rd_n idle", c_rd_n, 1);
        chk("ws rdata", c_rdata, 32'h7788_5566);

        // ---- reset during beat 1 of a 32-bit write ----
        tick();
        a_wstrb = 1; cpu_addr = 32'h0000_0100; cpu_wdata = 32'hCAFE_F00D; cpu_mask = 4'hF;
        smp(); chk("wrst c0 wbusy", a_wbusy, 1);
        tick(); a_wstrb = 0;
        smp();
        chk("wrst b0 wr_n", a_wr_n, 0);
        chk("wrst b0 data_out", a_dout, 16'hF00D);
        tick(); rst = 1'b1;
        smp();
        chk("wrst b1 data_out", a_dout, 16'hCAFE);
        chk("wrst b1 addr", a_addr, 32'h0000_0102);
        tick(); rst = 1'b0;
        smp();
        chk("wrst wr_n", a_wr_n, 1);
        chk("wrst data_oe", a_oe, 0);
        chk("wrst wbusy", a_wbusy, 0);
        chk("wrst mreq_n", a_mreq_n, 1);
        chk("wrst addr", a_addr, 0);
        chk("wrst rdata cleared", a_rdata, 0);

        // ---- wait_n held low ----
        tick();
        a_rstrb = 1; a_wait_n = 0; cpu_addr = 32'h0000_0020; cpu_mask = 4'h3;
        smp();
`ifdef RV_BUS_BRIDGE_TIMEOUT_EN
        for (int i = 1; i <= 5; i++) begin
            tick(); a_rstrb = 0; a_din = 16'h1111;
            smp();
            if (i <= 4) chk("tmo rd_n held", a_rd_n, 0);
        end
        chk("tmo rd_n released", a_rd_n, 1);
        chk("tmo rbusy", a_rbusy, 0);
        chk("tmo rdata", a_rdata, 32'h0000_FFFF);
        chk("tmo bus_err", a_err, 1);
        // a later good read leaves bus_err set
        tick();
        a_rstrb = 1; a_wait_n = 1; a_din = 16'h5A5A; cpu_addr = 32'h0000_0024; cpu_mask = 4'hC;
        smp();
        tick(); a_rstrb = 0;
        smp(); chk("tmo2 addr", a_addr, 32'h0000_0026);
        tick();
        smp();
        chk("tmo2 rdata", a_rdata, 32'h5A5A_FFFF);
        chk("tmo2 bus_err sticky", a_err, 1);
`else
        for (int i = 1; i <= 10; i++) begin
            tick();
            a_rstrb = 0;
            if (i == 9) begin a_wait_n = 1; a_din = 16'h4242; end
            else a_din = 16'h1111;
            smp();
            if (i <= 9) chk("stall rd_n", a_rd_n, 0);
            if (i == 8) chk("stall bus_err", a_err, 0);
        end
        chk("stall rbusy", a_rbusy, 0);
        chk("stall rdata", a_rdata, 32'h0000_4242);
        chk("stall bus_err end", a_err, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
